// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: PLL reset/lock sequencer with lock timeout, bounded retries,
// a lock-stability qualifier and re-sequencing on lock loss.
// Define PLL_LOSS_COUNTER_EN to build the saturating loss_cnt register; otherwise loss_cnt reads 0.
module pll_lock_supervisor #(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               lock_async,
    output logic                               pll_reset,
    output logic                               user_rst,
    output logic                               ready,
    output logic                               fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic [7:0]                         loss_cnt,
    output logic [2:0]                         state
);
    localparam int RW    = $clog2(MAX_RETRIES + 1);
    localparam int CMAX0 = RESET_CYCLES > LOCK_TIMEOUT ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int CMAX  = CMAX0 > STABLE_CYCLES ? CMAX0 : STABLE_CYCLES;
    localparam int CW    = $clog2(CMAX);
    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_STABLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_FAIL   = 3'd4;

    logic [1:0]    sync_q;
    logic          lock_s;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;

    assign lock_s = sync_q[1];

    // synchronizer, state, shared counter and retry count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= S_RESET;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            sync_q  <= {sync_q[0], lock_async};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    // next state; lock beats a same-cycle timeout, counter restarts on every state entry
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            S_RESET:  if (cnt_q == CW'(RESET_CYCLES - 1)) state_d = S_WAIT;
            S_WAIT: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_q + RW'(1);
                    state_d = (int'(retry_q) + 1 == MAX_RETRIES) ? S_FAIL : S_RESET;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT;
                end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end
            end
            S_RUN:    if (!lock_s) state_d = S_RESET;
            S_FAIL:   state_d = S_FAIL;
            default:  state_d = S_RESET;
        endcase
        cnt_d = (state_d != state_q || state_q == S_RUN || state_q == S_FAIL) ? '0 : cnt_q + CW'(1);
    end

    // outputs decode the registered state only
    always_comb begin
        pll_reset = state_q == S_RESET || state_q == S_FAIL;
        user_rst  = state_q != S_RUN;
        ready     = state_q == S_RUN;
        fail      = state_q == S_FAIL;
    end

    assign state     = state_q;
    assign retry_cnt = retry_q;

`ifdef PLL_LOSS_COUNTER_EN
    logic [7:0] loss_q;

    // count lock drops seen while running, saturating at 255
    always_ff @(posedge clk) begin
        if (rst)
            loss_q <= '0;
        else if (state_q == S_RUN && !lock_s && loss_q != 8'hff)
            loss_q <= loss_q + 8'd1;
    end

    assign loss_cnt = loss_q;
`else
    assign loss_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: segment table plus scoreboard for the PLL lock sequencer.
module tb_pll_lock_supervisor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock_async = 1'b0;
    logic       pll_reset, user_rst, ready, fail;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state;

`ifdef PLL_LOSS_COUNTER_EN
    localparam int LOSS_EN = 1;
`else
    localparam int LOSS_EN = 0;
`endif

    pll_lock_supervisor #(
        .RESET_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_RETRIES(2)
    ) dut (
        .clk(clk), .rst(rst), .lock_async(lock_async),
        .pll_reset(pll_reset), .user_rst(user_rst), .ready(ready), .fail(fail),
        .retry_cnt(retry_cnt), .loss_cnt(loss_cnt), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit r;
        bit l;
        int n;
        int st;
        int rc;
        int loss;
    } vec_t;

    typedef struct {
        int cyc;
        int st;
        int rc;
        int loss;
        int id;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    exp_t e;
    int   edges = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input int id, input string what, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL step%0d %s: got %0d expected %0d", id, what, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= edges) begin
            e = sb.pop_front();
            chk(e.id, "state", int'(state), e.st);
            chk(e.id, "retry_cnt", int'(retry_cnt), e.rc);
            chk(e.id, "loss_cnt", int'(loss_cnt), e.loss);
            chk(e.id, "pll_reset", int'(pll_reset), int'(e.st == 0 || e.st == 4));
            chk(e.id, "user_rst", int'(user_rst), int'(e.st != 3));
            chk(e.id, "ready", int'(ready), int'(e.st == 3));
            chk(e.id, "fail", int'(fail), int'(e.st == 4));
        end
    end

    function automatic void add(input bit r, input bit l, input int n, input int st, input int rc, input int loss);
        vec_t v;
        v.r = r; v.l = l; v.n = n; v.st = st; v.rc = rc; v.loss = loss;
        vt.push_back(v);
    endfunction

    task automatic seg(input bit r, input bit l, input int n, input int st, input int rc, input int loss, input int id);
        exp_t x;
        for (int i = 0; i < n; i++) begin
            rst = r;
            lock_async = l;
            @(posedge clk);
            #1;
        end
        x.cyc = edges; x.st = st; x.rc = rc; x.loss = loss * LOSS_EN; x.id = id;
        sb.push_back(x);
    endtask

    initial begin
        // clean start with lock held high
        add(1, 1, 2, 0, 0, 0);
        add(0, 1, 3, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        add(0, 1, 1, 2, 0, 0);
        add(0, 1, 7, 2, 0, 0);
        add(0, 1, 1, 3, 0, 0);
        add(0, 1, 5, 3, 0, 0);
        // lock loss in RUN for 10 cycles, then recovery
        add(0, 0, 2, 3, 0, 0);
        add(0, 0, 1, 0, 0, 1);
        add(0, 0, 3, 0, 0, 1);
        add(0, 0, 1, 1, 0, 1);
        add(0, 0, 3, 1, 0, 1);
        add(0, 1, 2, 1, 0, 1);
        add(0, 1, 1, 2, 0, 1);
        add(0, 1, 7, 2, 0, 1);
        add(0, 1, 1, 3, 0, 1);
        // reset while running
        add(1, 1, 1, 0, 0, 0);
        // never locks: two attempts then FAIL, which ignores lock
        add(1, 0, 1, 0, 0, 0);
        add(0, 0, 3, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0);
        add(0, 0, 19, 1, 0, 0);
        add(0, 0, 1, 0, 1, 0);
        add(0, 0, 3, 0, 1, 0);
        add(0, 0, 1, 1, 1, 0);
        add(0, 0, 19, 1, 1, 0);
        add(0, 0, 1, 4, 2, 0);
        add(0, 1, 6, 4, 2, 0);
        add(1, 0, 1, 0, 0, 0);
        // one timeout, unstable lock, restarted timeout ending in a lock/timeout tie
        add(0, 0, 3, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0);
        add(0, 0, 19, 1, 0, 0);
        add(0, 0, 1, 0, 1, 0);
        add(0, 0, 3, 0, 1, 0);
        add(0, 0, 1, 1, 1, 0);
        add(0, 1, 2, 1, 1, 0);
        add(0, 1, 1, 2, 1, 0);
        add(0, 1, 3, 2, 1, 0);
        add(0, 0, 2, 2, 1, 0);
        add(0, 0, 1, 1, 1, 0);
        add(0, 0, 17, 1, 1, 0);
        add(0, 1, 2, 1, 1, 0);
        add(0, 1, 1, 2, 1, 0);
        add(0, 1, 7, 2, 1, 0);
        add(0, 1, 1, 3, 0, 0);
        foreach (vt[i]) seg(vt[i].r, vt[i].l, vt[i].n, vt[i].st, vt[i].rc, vt[i].loss, i);
        // 300 lock losses in RUN: loss_cnt saturates at 255
        for (int i = 1; i <= 300; i++) begin
            seg(0, 0, 2, 3, 0, (i - 1 > 255) ? 255 : i - 1, 1000 + i);
            seg(0, 1, 14, 3, 0, (i > 255) ? 255 : i, 1000 + i);
        end
        seg(0, 1, 3, 3, 0, 255, 2000);
        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
